// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage in front of the 32-bit ALU.
//
// The stage takes one MIPS instruction per cycle with its GPR operands. It
// decodes each instruction into an ALU function code, two operands and the
// side-band flags that EX needs to interpret the ALU's z/v/neq outputs. The
// decoded op is held in a registered elastic buffer, so an EX stall never
// reaches back combinationally into decode.
//
// Build option:
//   ALU_ISSUE_SHIFTV_EN - when defined, SLLV/SRLV/SRAV (funct 04/06/07) are
//                         decoded. When undefined they issue as illegal NOPs,
//                         which removes the rs->b shift-operand path.
//
// Parameters:
//   SKID = 1 : two-entry skid buffer (EMPTY/ONE/TWO), registered in_ready
//   SKID = 0 : single output register, in_ready = ~out_valid | out_ready
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop every buffered entry and this cycle's input
//   in_valid/in_ready    input handshake
//   in_instr             instruction word
//   in_rs_val/in_rt_val  GPR[rs], GPR[rt]
//   out_valid/out_ready  output handshake toward EX
//   out_aluc             ALU function code
//   out_a/out_b          ALU operands
//   out_wreg/out_wen     destination register and its write enable
//   out_ovf_chk          ALU v raises an overflow trap
//   out_br_eq/out_br_ne  branch-taken conditions on ALU z / neq
//   out_mem_rd/out_mem_wr  load / store
//   out_ill              unsupported instruction, issued as a NOP
module alu_issue #(
   parameter int SKID = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_aluc,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [4:0]  out_wreg,
   output logic        out_wen,
   output logic        out_ovf_chk,
   output logic        out_br_eq,
   output logic        out_br_ne,
   output logic        out_mem_rd,
   output logic        out_mem_wr,
   output logic        out_ill
);

   typedef struct packed {
      logic [3:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wreg;
      logic        wen;
      logic        ovf_chk;
      logic        br_eq;
      logic        br_ne;
      logic        mem_rd;
      logic        mem_wr;
      logic        ill;
   } dec_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
`ifdef ALU_ISSUE_SHIFTV_EN
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
`endif

   logic [5:0]  w_opcode;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [5:0]  w_funct;
   logic [31:0] w_imm_sext;
   logic [31:0] w_imm_zext;
   logic        w_unused_rs;
   logic        w_writes;
   dec_t        w_dec;
   logic        w_accept;
   logic        w_pop;

   dec_t        r_head;
   logic        r_out_valid;

   assign w_opcode   = in_instr[31:26];
   assign w_rt       = in_instr[20:16];
   assign w_rd       = in_instr[15:11];
   assign w_shamt    = in_instr[10:6];
   assign w_funct    = in_instr[5:0];
   assign w_imm_sext = {{16{in_instr[15]}}, in_instr[15:0]};
   assign w_imm_zext = {16'h0000, in_instr[15:0]};
   // The rs field selects the register file port upstream; here only its value is used.
   assign w_unused_rs = &{1'b0, in_instr[25:21]};

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_dec    = '0;
      w_writes = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            w_dec.wreg = w_rd;
            w_dec.a    = in_rs_val;
            w_dec.b    = in_rt_val;
            w_writes   = 1'b1;
            case (w_funct)
               FN_SLL: begin
                  w_dec.aluc = 4'b0011;
                  w_dec.a    = in_rt_val;
                  w_dec.b    = {27'b0, w_shamt};
               end
               FN_SRL: begin
                  w_dec.aluc = 4'b0111;
                  w_dec.a    = in_rt_val;
                  w_dec.b    = {27'b0, w_shamt};
               end
               FN_SRA: begin
                  w_dec.aluc = 4'b1111;
                  w_dec.a    = in_rt_val;
                  w_dec.b    = {27'b0, w_shamt};
               end
`ifdef ALU_ISSUE_SHIFTV_EN
               // Variable shifts: the ALU only looks at b[4:0].
               FN_SLLV: begin
                  w_dec.aluc = 4'b0011;
                  w_dec.a    = in_rt_val;
                  w_dec.b    = in_rs_val;
               end
               FN_SRLV: begin
                  w_dec.aluc = 4'b0111;
                  w_dec.a    = in_rt_val;
                  w_dec.b    = in_rs_val;
               end
               FN_SRAV: begin
                  w_dec.aluc = 4'b1111;
                  w_dec.a    = in_rt_val;
                  w_dec.b    = in_rs_val;
               end
`endif
               FN_ADD: begin
                  w_dec.aluc    = 4'b0000;
                  w_dec.ovf_chk = 1'b1;
               end
               FN_ADDU: w_dec.aluc = 4'b0000;
               FN_SUB: begin
                  w_dec.aluc    = 4'b0100;
                  w_dec.ovf_chk = 1'b1;
               end
               FN_SUBU: w_dec.aluc = 4'b0100;
               FN_AND:  w_dec.aluc = 4'b0001;
               FN_OR:   w_dec.aluc = 4'b0101;
               FN_XOR:  w_dec.aluc = 4'b0010;
               default: w_dec.ill  = 1'b1;
            endcase
         end
         OP_BEQ, OP_BNE: begin
            // Branches compare rs and rt through the subtractor.
            w_dec.aluc  = 4'b0100;
            w_dec.a     = in_rs_val;
            w_dec.b     = in_rt_val;
            w_dec.wreg  = w_rt;
            w_dec.br_eq = (w_opcode == OP_BEQ);
            w_dec.br_ne = (w_opcode == OP_BNE);
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            w_dec.aluc    = 4'b0000;
            w_dec.a       = in_rs_val;
            w_dec.b       = w_imm_sext;
            w_dec.wreg    = w_rt;
            w_dec.ovf_chk = (w_opcode == OP_ADDI);
            w_dec.mem_rd  = (w_opcode == OP_LW);
            w_dec.mem_wr  = (w_opcode == OP_SW);
            w_writes      = (w_opcode != OP_SW);
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            w_dec.a    = in_rs_val;
            w_dec.b    = w_imm_zext;
            w_dec.wreg = w_rt;
            w_writes   = 1'b1;
            case (w_opcode)
               OP_ANDI: w_dec.aluc = 4'b0001;
               OP_ORI:  w_dec.aluc = 4'b0101;
               OP_XORI: w_dec.aluc = 4'b0010;
               default: w_dec.aluc = 4'b0110;
            endcase
         end
         default: w_dec.ill = 1'b1;
      endcase
      // Unsupported ops travel down the pipe as a clean NOP with only ill set.
      if (w_dec.ill) begin
         w_dec     = '0;
         w_dec.ill = 1'b1;
         w_writes  = 1'b0;
      end
      w_dec.wen = w_writes & (w_dec.wreg != 5'd0);
   end

   // ---------------------------------------------------------------- buffer
   assign w_accept = in_valid & in_ready;
   assign w_pop    = r_out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         state_t r_state;
         dec_t   r_skid;
         logic   r_in_ready;

         // r_head is always the oldest entry; r_skid only fills in state TWO.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_state     <= ST_EMPTY;
               r_head      <= '0;
               r_skid      <= '0;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end else if (flush) begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end else begin
               case (r_state)
                  ST_EMPTY: begin
                     if (w_accept) begin
                        r_head      <= w_dec;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                     end
                  end
                  ST_ONE: begin
                     if (w_accept && w_pop) begin
                        r_head <= w_dec;
                     end else if (w_accept) begin
                        r_skid     <= w_dec;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                     end else if (w_pop) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                     end
                  end
                  ST_TWO: begin
                     // in_ready is low here, so no accept can coincide.
                     if (w_pop) begin
                        r_head     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                     end
                  end
                  default: begin
                     r_state     <= ST_EMPTY;
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                  end
               endcase
            end
         end

         assign in_ready = r_in_ready;
      end else begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               r_head      <= '0;
               r_out_valid <= 1'b0;
            end else if (flush) begin
               r_out_valid <= 1'b0;
            end else if (w_accept) begin
               r_head      <= w_dec;
               r_out_valid <= 1'b1;
            end else if (w_pop) begin
               r_out_valid <= 1'b0;
            end
         end

         assign in_ready = ~r_out_valid | out_ready;
      end
   endgenerate

   assign out_valid   = r_out_valid;
   assign out_aluc    = r_head.aluc;
   assign out_a       = r_head.a;
   assign out_b       = r_head.b;
   assign out_wreg    = r_head.wreg;
   assign out_wen     = r_head.wen;
   assign out_ovf_chk = r_head.ovf_chk;
   assign out_br_eq   = r_head.br_eq;
   assign out_br_ne   = r_head.br_ne;
   assign out_mem_rd  = r_head.mem_rd;
   assign out_mem_wr  = r_head.mem_wr;
   assign out_ill     = r_head.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue (SKID=1). Directed instructions with hand-computed
// decodes; expected ops go into a queue on accept and a negedge monitor
// compares every presented op against the queue head, popping on handshake.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_aluc;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_wreg;
   logic        out_wen;
   logic        out_ovf_chk;
   logic        out_br_eq;
   logic        out_br_ne;
   logic        out_mem_rd;
   logic        out_mem_wr;
   logic        out_ill;

   always #5 clk = ~clk;

   alu_issue #(.SKID(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_aluc(out_aluc), .out_a(out_a), .out_b(out_b),
      .out_wreg(out_wreg), .out_wen(out_wen), .out_ovf_chk(out_ovf_chk),
      .out_br_eq(out_br_eq), .out_br_ne(out_br_ne),
      .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_ill(out_ill)
   );

   typedef struct packed {
      logic [3:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wreg;
      logic [6:0]  fl;   // {wen, ovf_chk, br_eq, br_ne, mem_rd, mem_wr, ill}
   } exp_t;

   localparam logic [6:0] F_WEN = 7'b1000000;
   localparam logic [6:0] F_OVF = 7'b0100000;
   localparam logic [6:0] F_BEQ = 7'b0010000;
   localparam logic [6:0] F_BNE = 7'b0001000;
   localparam logic [6:0] F_MRD = 7'b0000100;
   localparam logic [6:0] F_MWR = 7'b0000010;
   localparam logic [6:0] F_ILL = 7'b0000001;

   exp_t q[$];
   exp_t act;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   assign act = {out_aluc, out_a, out_b, out_wreg,
                 {out_wen, out_ovf_chk, out_br_eq, out_br_ne, out_mem_rd, out_mem_wr, out_ill}};

   always @(posedge clk) cyc++;

   function automatic exp_t mk(input logic [3:0] aluc, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wreg,
                               input logic [6:0] fl);
      exp_t e;
      e.aluc = aluc; e.a = a; e.b = b; e.wreg = wreg; e.fl = fl;
      return e;
   endfunction

   task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Monitor: every presented op must equal the queue head; pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected got=%h want=none", act);
         end else begin
            chk("out", act, q[0]);
            if (out_ready) begin
               $display("ISSUE aluc=%b a=%h b=%h wreg=%0d flags=%b", out_aluc, out_a, out_b, out_wreg, act.fl);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input exp_t e);
      logic rdy;
      logic ok;
      ok        = 1'b0;
      in_valid  = 1'b1;
      in_instr  = ins;
      in_rs_val = rs;
      in_rt_val = rt;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         q.push_back(e);
         $display("ACCEPT instr=%h rs=%h rt=%h", ins, rs, rt);
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got=no_accept want=accept instr=%h", ins);
      end
      // Garbage after the accept edge: only the accept-edge values may be used.
      in_valid  = 1'b0;
      in_instr  = 32'hFFFF_FFFF;
      in_rs_val = $urandom();
      in_rt_val = $urandom();
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 100; k++) begin
         if (q.size() == 0 && !out_valid) break;
         @(posedge clk);
         #1;
      end
      chk("drain", {79'b0, (q.size() == 0 && !out_valid)}, 80'd1);
   endtask

   int c0;

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_rs_val = '0;
      in_rt_val = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_data", act, 0);
      rst = 1'b0;

      // ADDI $t0,$zero,-1 : one-cycle latency
      issue(32'h2008FFFF, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'hFFFFFFFF, 5'd8, F_WEN | F_OVF));
      chk("latency_valid", out_valid, 1);

      // Back-to-back decode group with out_ready=1: one op per cycle.
      c0 = cyc;
      issue(32'h3C091234, 32'h0, 32'h0, mk(4'b0110, 32'h0, 32'h00001234, 5'd9, F_WEN));           // LUI
      issue(32'h356A8000, 32'h0F0F0000, 32'h1, mk(4'b0101, 32'h0F0F0000, 32'h00008000, 5'd10, F_WEN)); // ORI
      issue(32'h000B5103, 32'h12345678, 32'h80000000, mk(4'b1111, 32'h80000000, 32'd4, 5'd10, F_WEN)); // SRA
`ifdef ALU_ISSUE_SHIFTV_EN
      issue(32'h018B5007, 32'h00000003, 32'hF0000000, mk(4'b1111, 32'hF0000000, 32'h00000003, 5'd10, F_WEN)); // SRAV
`else
      issue(32'h018B5007, 32'h00000003, 32'hF0000000, mk(4'b0000, 32'h0, 32'h0, 5'd0, F_ILL));     // SRAV illegal
`endif
      chk("throughput", cyc - c0, 4);
      issue(32'h15090010, 32'd5, 32'd6, mk(4'b0100, 32'd5, 32'd6, 5'd9, F_BNE));                    // BNE
      issue(32'hAFA9FFF8, 32'h1000, 32'hDEAD, mk(4'b0000, 32'h1000, 32'hFFFFFFF8, 5'd9, F_MWR));    // SW
      issue(32'h02328022, 32'd100, 32'd30, mk(4'b0100, 32'd100, 32'd30, 5'd16, F_WEN | F_OVF));     // SUB
      issue(32'h00220021, 32'd7, 32'd9, mk(4'b0000, 32'd7, 32'd9, 5'd0, 7'b0));                     // ADDU $0
      issue(32'h10000003, 32'h55, 32'h55, mk(4'b0100, 32'h55, 32'h55, 5'd0, F_BEQ));               // BEQ
      issue(32'h8FA80004, 32'h2000, 32'h0, mk(4'b0000, 32'h2000, 32'h4, 5'd8, F_WEN | F_MRD));      // LW
      issue(32'h000947C0, 32'h0, 32'h1, mk(4'b0011, 32'h1, 32'd31, 5'd8, F_WEN));                   // SLL 31
      issue(32'h00094042, 32'h0, 32'hA0, mk(4'b0111, 32'hA0, 32'd1, 5'd8, F_WEN));                  // SRL 1
      issue(32'h012A4024, 32'hFF00, 32'h0FF0, mk(4'b0001, 32'hFF00, 32'h0FF0, 5'd8, F_WEN));        // AND
      issue(32'h3928FFFF, 32'h1234, 32'h0, mk(4'b0010, 32'h1234, 32'h0000FFFF, 5'd8, F_WEN));       // XORI
      issue(32'h08000000, 32'h1, 32'h2, mk(4'b0000, 32'h0, 32'h0, 5'd0, F_ILL));                    // J (illegal)
      issue(32'h03E00008, 32'h1, 32'h2, mk(4'b0000, 32'h0, 32'h0, 5'd0, F_ILL));                    // JR (illegal)
      wait_drain();

      // Stall: two accepted, third held off, outputs frozen on op1.
      out_ready = 1'b0;
      issue(32'h012A4024, 32'hAAAA, 32'h00FF, mk(4'b0001, 32'hAAAA, 32'h00FF, 5'd8, F_WEN));
      chk("stall_rdy1", in_ready, 1);
      issue(32'h3928FFFF, 32'h5555, 32'h0, mk(4'b0010, 32'h5555, 32'h0000FFFF, 5'd8, F_WEN));
      chk("stall_rdy2", in_ready, 0);
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("stall_hold_rdy", in_ready, 0);
            chk("stall_hold_valid", out_valid, 1);
            out_ready = 1'b1;
         end
         issue(32'h000947C0, 32'h0, 32'h3, mk(4'b0011, 32'h3, 32'd31, 5'd8, F_WEN));
      join
      wait_drain();

      // Flush with two entries buffered while another op is offered.
      out_ready = 1'b0;
      issue(32'h2008FFFF, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'hFFFFFFFF, 5'd8, F_WEN | F_OVF));
      issue(32'h3C091234, 32'h0, 32'h0, mk(4'b0110, 32'h0, 32'h00001234, 5'd9, F_WEN));
      in_valid = 1'b1;
      in_instr = 32'h012A4024;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      chk("flush2_valid", out_valid, 0);
      chk("flush2_rdy", in_ready, 1);
      out_ready = 1'b1;
      issue(32'h15090010, 32'd1, 32'd2, mk(4'b0100, 32'd1, 32'd2, 5'd9, F_BNE));
      wait_drain();

      // Flush with one entry buffered and an input handshaking that cycle.
      out_ready = 1'b0;
      issue(32'h02328022, 32'd9, 32'd4, mk(4'b0100, 32'd9, 32'd4, 5'd16, F_WEN | F_OVF));
      chk("flush1_pre_rdy", in_ready, 1);
      in_valid  = 1'b1;
      in_instr  = 32'h3C091234;
      in_rs_val = 32'h0;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      chk("flush1_valid", out_valid, 0);
      chk("flush1_rdy", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("flush1_dropped", out_valid, 0);
      out_ready = 1'b1;
      issue(32'hAFA9FFF8, 32'h40, 32'h1, mk(4'b0000, 32'h40, 32'hFFFFFFF8, 5'd9, F_MWR));
      wait_drain();

      // Reset mid-operation clears entries and data.
      out_ready = 1'b0;
      issue(32'h012A4024, 32'hFFFF, 32'hF0F0, mk(4'b0001, 32'hFFFF, 32'hF0F0, 5'd8, F_WEN));
      issue(32'h8FA80004, 32'h300, 32'h0, mk(4'b0000, 32'h300, 32'h4, 5'd8, F_WEN | F_MRD));
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      chk("rst2_valid", out_valid, 0);
      chk("rst2_rdy", in_ready, 1);
      chk("rst2_data", act, 0);
      rst       = 1'b0;
      out_ready = 1'b1;
      issue(32'h00094042, 32'h0, 32'h8, mk(4'b0111, 32'h8, 32'd1, 5'd8, F_WEN));
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
